dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit scratchpad words (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset:
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  synchronous reset, active-low
REQ-004 Request and response ports SHALL be:
- dc_addr_i  in  32  request byte address
- dc_data_i  in  32  store data, right-aligned for sub-word stores
- dc_op_i  in  3  operation code
- dc_valid_i  in  1  request strobe, one cycle
- dc_data_o  out  32  load result, 0 for stores/errors
- dc_valid_o  out  1  response strobe, one cycle
- dc_err_o  out  1  qualifies dc_valid_o: misaligned or out-of-range
- busy_o  out  1  high when state != IDLE
- req_drop_o  out  1  sticky: request arrived while busy
REQ-005 Host preload ports SHALL be:
- host_we_i  in  1  host word write
- host_addr_i  in  $clog2(DEPTH_WORDS)  word index
- host_data_i  in  32  write data
- host_ready_o  out  1  host write accepted this cycle

Function
REQ-006 dc_op_i SHALL decode as: 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 The FSM SHALL have states IDLE, RD, WR, RESP; only IDLE accepts requests.
REQ-008 Accepted requests SHALL be latched (address, data, op) in the accept cycle.
REQ-009 Load or error: IDLE->RD->RESP; dc_valid_o asserts exactly 2 cycles after accept.
REQ-010 SW: IDLE->WR->RESP; word written in WR; dc_valid_o 2 cycles after accept.
REQ-011 SH/SB: IDLE->RD->WR->RESP; read-modify-write merges only addressed lanes; dc_valid_o 3 cycles after accept.
REQ-012 RESP SHALL last one cycle, drive dc_valid_o=1, then return to IDLE.
REQ-013 Byte lanes SHALL be little-endian, selected by addr[1:0]; half lane by addr[1].
REQ-014 LH/LB SHALL sign-extend to 32 bits; LHU/LBU SHALL zero-extend.
REQ-015 Word index SHALL be (addr - BASE_ADDR)>>2, unsigned 32-bit subtraction; index >= DEPTH_WORDS is out-of-range.
REQ-016 Error cases: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]=1, or out-of-range SHALL respond with dc_err_o=1, dc_data_o=0, and no scratchpad write.
REQ-017 dc_valid_i while busy_o=1 SHALL be ignored (no response) and SHALL set req_drop_o until reset.
REQ-018 host_ready_o SHALL be 1 only in IDLE with dc_valid_i=0; the host write commits that cycle. dc_valid_i wins over a simultaneous host_we_i.
REQ-019 A request accepted in the cycle RESP returns to IDLE SHALL NOT be possible; the next accept is earliest the cycle after RESP.
REQ-020 dc_data_o and dc_err_o SHALL be 0 whenever dc_valid_o=0.

Reset
REQ-021 While rst_i=0: state IDLE, dc_valid_o=0, dc_data_o=0, dc_err_o=0, busy_o=0, req_drop_o=0, host_ready_o=0.
REQ-022 Reset mid-operation SHALL abort without response; a WR coinciding with reset SHALL NOT commit; scratchpad contents are not cleared.

Structure
REQ-023 Package dcache_pkg SHALL hold the dc_op enum, FSM state enum and lane-extract/merge functions.
REQ-024 Sub-module dcache_sram (single-port, registered read, one-cycle read latency) SHALL hold storage; the host port muxes into it.

Verification
REQ-025 Host writes word 5 = 32'h8081_F2F3; LW addr 0x14 -> dc_valid_o 2 cycles later, data 32'h8081_F2F3, err 0.
REQ-026 Same word: LB addr 0x15 -> 32'hFFFF_FFF2; LBU 0x15 -> 32'h0000_00F2; LH 0x16 -> 32'hFFFF_8081.
REQ-027 SB addr 0x16 data 32'h0000_00AA -> response 3 cycles later; then LW 0x14 -> 32'h80AA_F2F3.
REQ-028 LW addr 0x13 -> err 1, data 0; SW addr 0x1000 (DEPTH 1024) -> err 1, word 0 unchanged.
REQ-029 SH accepted, second dc_valid_i next cycle -> single response, req_drop_o=1 until reset.
REQ-030 SW accepted, rst_i=0 in WR cycle -> no dc_valid_o, target word keeps old value, all outputs at reset values.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the data-cache scratchpad responder.
package dcache_pkg;

  typedef enum logic [2:0] {
    OpLw  = 3'b000,
    OpLh  = 3'b001,
    OpLb  = 3'b010,
    OpLhu = 3'b011,
    OpLbu = 3'b100,
    OpSw  = 3'b101,
    OpSh  = 3'b110,
    OpSb  = 3'b111
  } dc_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StResp = 2'b11
  } dc_state_e;

  function automatic logic is_load(dc_op_e op);
    return (op == OpLw) || (op == OpLh) || (op == OpLb) || (op == OpLhu) || (op == OpLbu);
  endfunction

  function automatic logic misaligned(dc_op_e op, logic [1:0] off);
    case (op)
      OpLw, OpSw:        return off != 2'b00;
      OpLh, OpLhu, OpSh: return off[0];
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(logic [31:0] w, dc_op_e op, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0000, h};
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h00_0000, b};
      default: return w;
    endcase
  endfunction

  // Store data arrives right-aligned; shift it into the addressed lane(s).
  function automatic logic [31:0] lane_merge(logic [31:0] old, logic [31:0] data, dc_op_e op,
                                             logic [1:0] off);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = {off, 3'b000};
    case (op)
      OpSb:    mask = 32'h0000_00ff << sh;
      OpSh: begin
        sh   = {off[1], 4'b0000};
        mask = 32'h0000_ffff << sh;
      end
      default: mask = 32'hffff_ffff;
    endcase
    return (old & ~mask) | ((data << sh) & mask);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Single-port word scratchpad with registered (one-cycle latency) read.
module dcache_sram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dcache_responder.sv
// Scratchpad data-cache responder: decodes loads/stores, does sub-word RMW, one response per request.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [31:0]                    dc_addr_i,
  input  logic [31:0]                    dc_data_i,
  input  logic [2:0]                     dc_op_i,
  input  logic                           dc_valid_i,
  output logic [31:0]                    dc_data_o,
  output logic                           dc_valid_o,
  output logic                           dc_err_o,
  output logic                           busy_o,
  output logic                           req_drop_o,
  input  logic                           host_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] host_addr_i,
  input  logic [31:0]                    host_data_i,
  output logic                           host_ready_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dc_state_e   state_q;
  dc_op_e      op_q;
  logic [AW-1:0] idx_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_data_q;
  logic        drop_q;

  dc_op_e      req_op;
  logic [31:0] req_off;
  logic [AW-1:0] req_idx;
  logic        req_err;
  logic        accept;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign req_op  = dc_op_e'(dc_op_i);
  assign req_off = dc_addr_i - BASE_ADDR;
  assign req_idx = req_off[AW+1:2];
  assign req_err = ((req_off >> 2) >= 32'(DEPTH_WORDS)) || misaligned(req_op, dc_addr_i[1:0]);
  assign accept  = rst_i && (state_q == StIdle) && dc_valid_i;

  assign host_ready_o = rst_i && (state_q == StIdle) && !dc_valid_i;

  // The read for a request is launched in the accept cycle so data is ready during RD.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = host_addr_i;
    ram_wdata = host_data_i;
    if (accept) begin
      ram_addr = req_idx;
    end else if (state_q == StRd) begin
      ram_addr = idx_q;
    end else if (state_q == StWr) begin
      ram_addr  = idx_q;
      ram_wdata = wdata_q;
      ram_we    = rst_i;
    end else if (host_ready_o) begin
      ram_we = host_we_i;
    end
  end

  dcache_sram #(
    .Depth (DEPTH_WORDS),
    .AddrW (AW)
  ) u_sram (
    .clk   (clk_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      if (dc_valid_i && (state_q != StIdle)) drop_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (dc_valid_i) begin
            op_q    <= req_op;
            idx_q   <= req_idx;
            off_q   <= dc_addr_i[1:0];
            wdata_q <= dc_data_i;
            err_q   <= req_err;
            state_q <= (!req_err && (req_op == OpSw)) ? StWr : StRd;
          end
        end
        StRd: begin
          if (err_q || is_load(op_q)) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_data_q  <= err_q ? '0 : lane_extract(ram_rdata, op_q, off_q);
            state_q      <= StResp;
          end else begin
            wdata_q <= lane_merge(ram_rdata, wdata_q, op_q, off_q);
            state_q <= StWr;
          end
        end
        StWr: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced to their reset values for the whole time reset is held.
  assign dc_valid_o = resp_valid_q & rst_i;
  assign dc_err_o   = resp_valid_q & rst_i & resp_err_q;
  assign dc_data_o  = (resp_valid_q & rst_i) ? resp_data_q : '0;
  assign busy_o     = rst_i && (state_q != StIdle);
  assign req_drop_o = drop_q & rst_i;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomised and directed bench for dcache_responder against a byte-addressed memory model.
module tb_dcache_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] dc_addr_i = '0;
  logic [31:0] dc_data_i = '0;
  logic [2:0]  dc_op_i = '0;
  logic        dc_valid_i = 1'b0;
  logic [31:0] dc_data_o;
  logic        dc_valid_o;
  logic        dc_err_o;
  logic        busy_o;
  logic        req_drop_o;
  logic        host_we_i = 1'b0;
  logic [9:0]  host_addr_i = '0;
  logic [31:0] host_data_i = '0;
  logic        host_ready_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] bmem [4*DEPTH];

  dcache_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dc_addr_i    (dc_addr_i),
    .dc_data_i    (dc_data_i),
    .dc_op_i      (dc_op_i),
    .dc_valid_i   (dc_valid_i),
    .dc_data_o    (dc_data_o),
    .dc_valid_o   (dc_valid_o),
    .dc_err_o     (dc_err_o),
    .busy_o       (busy_o),
    .req_drop_o   (req_drop_o),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_data_i  (host_data_i),
    .host_ready_o (host_ready_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: size/alignment/range rules applied to a flat byte memory.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] ed, output logic ee, output int el);
    int unsigned sz;
    bit ld, sg;
    logic [31:0] off, v;
    sz  = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd3 || op == 3'd6) ? 2 : 1;
    ld  = op < 3'd5;
    sg  = (op == 3'd1) || (op == 3'd2);
    off = addr - BASE;
    ee  = ((addr & 32'(sz - 1)) != 0) || (off >= 32'(4 * DEPTH));
    ed  = '0;
    el  = (!ee && (op == 3'd6 || op == 3'd7)) ? 3 : 2;
    if (!ee) begin
      if (ld) begin
        v = '0;
        for (int i = 0; i < int'(sz); i++) v |= 32'(bmem[off + 32'(i)]) << (8 * i);
        if (sg && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
        ed = v;
      end else begin
        for (int i = 0; i < int'(sz); i++) bmem[off + 32'(i)] = 8'(data >> (8 * i));
      end
    end
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    host_we_i   = 1'b1;
    host_addr_i = 10'(idx);
    host_data_i = d;
    #1;
    check("host_ready", {63'd0, host_ready_o}, 64'd1);
    @(negedge clk_i);
    host_we_i = 1'b0;
    for (int i = 0; i < 4; i++) bmem[idx * 4 + i] = 8'(d >> (8 * i));
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge after the response pulse.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input bit inject, output logic [31:0] got);
    logic [31:0] ed;
    logic        ee;
    int          el, n;
    model(op, addr, data, ed, ee, el);
    dc_op_i = op; dc_addr_i = addr; dc_data_i = data; dc_valid_i = 1'b1;
    #1;
    check("ready_vs_req", {63'd0, host_ready_o}, 64'd0);
    @(negedge clk_i);
    n = 1;
    dc_valid_i = inject; dc_op_i = 3'd0; dc_addr_i = '0;
    check("busy_after_accept", {63'd0, busy_o}, 64'd1);
    while (dc_valid_o !== 1'b1 && n < 10) begin
      check("quiet_outputs", {31'd0, dc_err_o, dc_data_o}, 64'd0);
      @(negedge clk_i);
      n++;
      dc_valid_i = 1'b0;
    end
    dc_valid_i = 1'b0;
    check($sformatf("latency op%0d a%0h", op, addr), 64'(n), 64'(el));
    check($sformatf("data op%0d a%0h", op, addr), {32'd0, dc_data_o}, {32'd0, ed});
    check($sformatf("err op%0d a%0h", op, addr), {63'd0, dc_err_o}, {63'd0, ee});
    got = dc_data_o;
    @(negedge clk_i);
    check("single_pulse", {63'd0, dc_valid_o}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, dc_valid_o}, 64'd0);
    check({tag, "_data"}, {32'd0, dc_data_o}, 64'd0);
    check({tag, "_err"}, {63'd0, dc_err_o}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_drop"}, {63'd0, req_drop_o}, 64'd0);
    check({tag, "_hready"}, {63'd0, host_ready_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] got;
    int          seen;
    for (int i = 0; i < 4 * int'(DEPTH); i++) bmem[i] = 8'h00;

    // Reset, with a host write attempt that must not be accepted.
    host_we_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    host_we_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 16; i++) host_write(i, $urandom);
    host_write(0, 32'hCAFE_0001);
    host_write(5, 32'h8081_F2F3);

    do_req(3'd0, 32'h14, 32'h0, 1'b0, got);
    check("lw_0x14", {32'd0, got}, {32'd0, 32'h8081_F2F3});
    do_req(3'd2, 32'h15, 32'h0, 1'b0, got);
    check("lb_0x15", {32'd0, got}, {32'd0, 32'hFFFF_FFF2});
    do_req(3'd4, 32'h15, 32'h0, 1'b0, got);
    check("lbu_0x15", {32'd0, got}, {32'd0, 32'h0000_00F2});
    do_req(3'd1, 32'h16, 32'h0, 1'b0, got);
    check("lh_0x16", {32'd0, got}, {32'd0, 32'hFFFF_8081});
    do_req(3'd7, 32'h16, 32'h0000_00AA, 1'b0, got);
    do_req(3'd0, 32'h14, 32'h0, 1'b0, got);
    check("lw_after_sb", {32'd0, got}, {32'd0, 32'h80AA_F2F3});
    do_req(3'd0, 32'h13, 32'h0, 1'b0, got);
    do_req(3'd5, 32'h1000, 32'h1234_5678, 1'b0, got);
    do_req(3'd0, 32'h0, 32'h0, 1'b0, got);
    check("word0_kept", {32'd0, got}, {32'd0, 32'hCAFE_0001});

    // Host write racing a request: request wins, write is lost.
    host_we_i = 1'b1; host_addr_i = 10'd7; host_data_i = 32'h5555_5555;
    do_req(3'd0, 32'h1C, 32'h0, 1'b0, got);
    host_we_i = 1'b0;
    do_req(3'd0, 32'h1C, 32'h0, 1'b0, got);

    // Second strobe while busy is dropped and flagged.
    check("drop_clear", {63'd0, req_drop_o}, 64'd0);
    do_req(3'd6, 32'h22, $urandom, 1'b1, got);
    seen = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (dc_valid_o) seen++;
    end
    check("no_extra_resp", 64'(seen), 64'd0);
    check("drop_set", {63'd0, req_drop_o}, 64'd1);
    do_req(3'd0, 32'h20, 32'h0, 1'b0, got);
    check("drop_sticky", {63'd0, req_drop_o}, 64'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("drop_reset", {63'd0, req_drop_o}, 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Reset during the WR cycle of a SW: no commit, no response.
    dc_op_i = 3'd5; dc_addr_i = 32'hC; dc_data_i = 32'hDEAD_BEEF; dc_valid_i = 1'b1;
    @(negedge clk_i);
    dc_valid_i = 1'b0;
    check("sw_busy", {63'd0, busy_o}, 64'd1);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("wr_abort");
    @(negedge clk_i);
    check_reset_outputs("wr_abort2");
    rst_i = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (dc_valid_o) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    do_req(3'd0, 32'hC, 32'h0, 1'b0, got);

    for (int k = 0; k < 150; k++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) host_write(int'($urandom_range(0, 15)), $urandom);
      do_req(op, addr, $urandom, 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
